motion_sequencer: RTL

- Command-level controller that drives the speed and direction inputs of the two-channel motor PWM generator.
- Accepts one motion command at a time over a valid/ready handshake: op, speed, duration.
- Ramps each wheel toward its target, ramping through zero whenever that wheel's direction must reverse. Holds the command for its duration, then ramps both wheels to zero and pulses done.
- Sits between the navigation FSM and the PWM generator.

---
 rtl/motion_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/motion_sequencer.sv
// Command-level motion controller: takes one wheel-motion command at a time and ramps
// the left/right PWM speed and direction channels through RAMP_UP, RUN and RAMP_DN.
module motion_sequencer #(
  parameter int MAX_SPEED = 11000,
  parameter int RAMP_DIV  = 1100,
  parameter int RAMP_STEP = 550,
  parameter int TICK_DIV  = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [13:0] cmd_speed,
  input  logic [15:0] cmd_dur,
  input  logic        abort,
  input  logic        estop,
  output logic [13:0] speed_l,
  output logic [13:0] speed_r,
  output logic        dir_l,
  output logic        dir_r,
  output logic        busy,
  output logic        done
);
  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [13:0]   MAX_SPD   = 14'(MAX_SPEED);
  localparam logic [14:0]   STEP      = 15'(RAMP_STEP);

  typedef enum logic [1:0] {ST_IDLE, ST_RAMP_UP, ST_RUN, ST_RAMP_DN} state_e;
  typedef enum logic [2:0] {
    OP_STOP, OP_FWD, OP_REV, OP_SPIN_L, OP_SPIN_R, OP_ARC_L, OP_ARC_R, OP_RSVD
  } op_e;
  typedef struct packed {
    logic        dir;
    logic [13:0] spd;
  } wheel_t;

  // One RAMP_STEP toward tgt in 15-bit arithmetic, landing exactly on tgt.
  function automatic logic [13:0] step_toward(input logic [13:0] cur, input logic [13:0] tgt);
    logic [14:0] c;
    logic [14:0] t;
    logic [14:0] r;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    if (c < t)      r = ((t - c) > STEP) ? c + STEP : t;
    else if (c > t) r = ((c - t) > STEP) ? c - STEP : t;
    else            r = c;
    return 14'(r);
  endfunction

  // A reversing wheel first drains to zero, then spends one strobe flipping direction.
  function automatic wheel_t ramp_wheel(input wheel_t cur, input wheel_t tgt);
    wheel_t nxt;
    nxt = cur;
    if (cur.dir != tgt.dir) begin
      if (cur.spd != 14'd0) nxt.spd = step_toward(cur.spd, 14'd0);
      else                  nxt.dir = tgt.dir;
    end else begin
      nxt.spd = step_toward(cur.spd, tgt.spd);
    end
    return nxt;
  endfunction

  state_e         state_q, state_d;
  logic [RW-1:0]  ramp_cnt_q, ramp_cnt_d;
  logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
  logic [15:0]    dur_cnt_q, dur_cnt_d;
  wheel_t         whl_l_q, whl_l_d, whl_r_q, whl_r_d;
  wheel_t         tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
  logic           done_q, done_d;

  logic           strobe;
  wheel_t         eff_tgt_l, eff_tgt_r;
  logic [13:0]    spd_sat, spd_half;

  assign strobe    = (ramp_cnt_q == RAMP_LAST);
  assign spd_sat   = (cmd_speed > MAX_SPD) ? MAX_SPD : cmd_speed;
  assign spd_half  = spd_sat >> 1;
  assign cmd_ready = (state_q == ST_IDLE) && !estop;

  // In RAMP_DN the targets collapse to zero speed in the current direction.
  assign eff_tgt_l = (state_q == ST_RAMP_DN) ? '{whl_l_q.dir, 14'd0} : tgt_l_q;
  assign eff_tgt_r = (state_q == ST_RAMP_DN) ? '{whl_r_q.dir, 14'd0} : tgt_r_q;

  always_comb begin
    // NOTE: every next-state value is defaulted first so no path through this block infers a latch.
    state_d    = state_q;
    ramp_cnt_d = strobe ? '0 : ramp_cnt_q + RW'(1);
    tick_cnt_d = tick_cnt_q;
    dur_cnt_d  = dur_cnt_q;
    whl_l_d    = whl_l_q;
    whl_r_d    = whl_r_q;
    tgt_l_d    = tgt_l_q;
    tgt_r_d    = tgt_r_q;
    done_d     = 1'b0;

    if (strobe && (state_q == ST_RAMP_UP || state_q == ST_RAMP_DN)) begin
      whl_l_d = ramp_wheel(whl_l_q, eff_tgt_l);
      whl_r_d = ramp_wheel(whl_r_q, eff_tgt_r);
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d   = ST_RAMP_UP;
          dur_cnt_d = cmd_dur;
          case (op_e'(cmd_op))
            OP_FWD:    begin tgt_l_d = '{1'b1, spd_sat};  tgt_r_d = '{1'b1, spd_sat};  end
            OP_REV:    begin tgt_l_d = '{1'b0, spd_sat};  tgt_r_d = '{1'b0, spd_sat};  end
            OP_SPIN_L: begin tgt_l_d = '{1'b0, spd_sat};  tgt_r_d = '{1'b1, spd_sat};  end
            OP_SPIN_R: begin tgt_l_d = '{1'b1, spd_sat};  tgt_r_d = '{1'b0, spd_sat};  end
            OP_ARC_L:  begin tgt_l_d = '{1'b1, spd_half}; tgt_r_d = '{1'b1, spd_sat};  end
            OP_ARC_R:  begin tgt_l_d = '{1'b1, spd_sat};  tgt_r_d = '{1'b1, spd_half}; end
            default:   begin
              tgt_l_d = '{whl_l_q.dir, 14'd0};
              tgt_r_d = '{whl_r_q.dir, 14'd0};
            end
          endcase
        end
      end
      ST_RAMP_UP: begin
        if (abort) begin
          state_d = ST_RAMP_DN;
        end else if (whl_l_q == tgt_l_q && whl_r_q == tgt_r_q) begin
          state_d    = ST_RUN;
          tick_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (abort || dur_cnt_q == 16'd0) begin
          state_d = ST_RAMP_DN;
        end else if (tick_cnt_q == TICK_LAST) begin
          tick_cnt_d = '0;
          dur_cnt_d  = dur_cnt_q - 16'd1;
        end else begin
          tick_cnt_d = tick_cnt_q + TW'(1);
        end
      end
      ST_RAMP_DN: begin
        tgt_l_d = eff_tgt_l;
        tgt_r_d = eff_tgt_r;
        if (whl_l_q.spd == 14'd0 && whl_r_q.spd == 14'd0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Emergency stop overrides everything except the held directions.
    if (estop) begin
      state_d     = ST_IDLE;
      whl_l_d.spd = 14'd0;
      whl_r_d.spd = 14'd0;
      done_d      = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ramp_cnt_q <= '0;
      tick_cnt_q <= '0;
      dur_cnt_q  <= '0;
      whl_l_q    <= '{1'b1, 14'd0};
      whl_r_q    <= '{1'b1, 14'd0};
      tgt_l_q    <= '{1'b1, 14'd0};
      tgt_r_q    <= '{1'b1, 14'd0};
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ramp_cnt_q <= ramp_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      dur_cnt_q  <= dur_cnt_d;
      whl_l_q    <= whl_l_d;
      whl_r_q    <= whl_r_d;
      tgt_l_q    <= tgt_l_d;
      tgt_r_q    <= tgt_r_d;
      done_q     <= done_d;
    end
  end

  assign speed_l = whl_l_q.spd;
  assign speed_r = whl_r_q.spd;
  assign dir_l   = whl_l_q.dir;
  assign dir_r   = whl_r_q.dir;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;

endmodule
